// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock-divider bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_div_pkg;

    localparam int DEF_N_CH     = 4;
    localparam int DEF_DIV_W    = 8;
    localparam int DEF_TAP_BITS = 4;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_idx_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Full output period in clk cycles for a given divisor.
    function automatic int period(input int div);
        return 2 * (div + 1);
    endfunction

endpackage

// File: rtl/clk_div_if.sv
// Control/config/output bundle between the divider bank and its driver.
// Latency: n/a (wiring only).
// Backpressure: cfg_valid/cfg_ready handshake; all other signals are free-running.
interface clk_div_if import clk_div_pkg::*; #(
    parameter int N_CH     = DEF_N_CH,
    parameter int DIV_W    = DEF_DIV_W,
    parameter int TAP_BITS = DEF_TAP_BITS
);
    localparam int CH_IDX_W = ch_idx_w(N_CH);

    logic                en;
    logic                sync;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_IDX_W-1:0] cfg_ch;
    logic [DIV_W-1:0]    cfg_div;
    logic [N_CH-1:0]     clk_out;
    logic [N_CH-1:0]     tick;
    logic [TAP_BITS-1:0] tap;

    modport master (
        output en, sync, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, clk_out, tick, tap
    );

    modport slave (
        input  en, sync, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, clk_out, tick, tap
    );

endinterface

// File: rtl/clk_div_chan.sv
// One programmable divider channel: half-period = div_act+1 cycles, tick on each edge.
// Latency: clk_out/tick registered, one cycle after the terminal count.
// Backpressure: pending blocks further writes until the next falling toggle or sync.
module clk_div_chan import clk_div_pkg::*; #(
    parameter int DIV_W     = DEF_DIV_W,
    parameter int RESET_DIV = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(RESET_DIV);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;

    // wr is only raised by the top while pending is clear, so a write and a
    // pending-apply never collide in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            div_act  <= RST_DIV;
            div_pend <= RST_DIV;
            pending  <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else if (sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (wr) begin
                div_act  <= wr_div;
                div_pend <= wr_div;
            end else if (pending) begin
                div_act <= div_pend;
            end
        end else begin
            tick <= 1'b0;
            if (wr) begin
                div_pend <= wr_div;
                pending  <= 1'b1;
            end
            if (en) begin
                if (cnt == div_act) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    tick    <= 1'b1;
                    // Swap divisors only at the 1->0 edge so each period stays symmetric.
                    if (clk_out && pending) begin
                        div_act <= div_pend;
                        pending <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// N_CH programmable clock dividers plus a free-running power-of-two tap chain.
// Latency: clk_out/tick/tap registered; cfg_ready combinational from cfg_ch.
// Backpressure: cfg_ready low while the addressed channel holds an unapplied divisor.
module clk_div_bank import clk_div_pkg::*; #(
    parameter int N_CH      = DEF_N_CH,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int TAP_BITS  = DEF_TAP_BITS,
    parameter int RESET_DIV = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    clk_div_if.slave bus
);
    localparam int CH_IDX_W = ch_idx_w(N_CH);
    localparam int N_IDX    = 1 << CH_IDX_W;

    logic [N_CH-1:0]     pending;
    logic [N_CH-1:0]     wr;
    logic [N_CH-1:0]     clk_out_w;
    logic [N_CH-1:0]     tick_w;
    logic [N_IDX-1:0]    ready_tab;
    logic [TAP_BITS-1:0] tap_q;

    // Unused select codes always accept so a stray write drains instead of hanging.
    for (genvar i = 0; i < N_IDX; i++) begin : g_rdy
        if (i < N_CH) begin : g_live
            assign ready_tab[i] = ~pending[i];
        end else begin : g_void
            assign ready_tab[i] = 1'b1;
        end
    end

    assign bus.cfg_ready = ready_tab[bus.cfg_ch];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr[i] = bus.cfg_valid & ~pending[i] & (bus.cfg_ch == CH_IDX_W'(i));

        clk_div_chan #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (bus.en),
            .sync    (bus.sync),
            .wr      (wr[i]),
            .wr_div  (bus.cfg_div),
            .pending (pending[i]),
            .clk_out (clk_out_w[i]),
            .tick    (tick_w[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= '0;
        end else if (bus.sync) begin
            tap_q <= '0;
        end else if (bus.en) begin
            tap_q <= tap_q + TAP_BITS'(1);
        end
    end

    assign bus.clk_out = clk_out_w;
    assign bus.tick    = tick_w;
    assign bus.tap     = tap_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: edge-interval scoreboard plus timed spot checks.
// Three channels so that select code 3 is an out-of-range channel.
module tb_clk_div_bank;
    import clk_div_pkg::*;

    localparam int N_CH     = 3;
    localparam int DIV_W    = 8;
    localparam int TAP_BITS = 4;

    typedef struct packed {
        int lvl;
        int hp;
    } exp_t;

    logic clk;
    logic rst_n;

    clk_div_if #(.N_CH(N_CH), .DIV_W(DIV_W), .TAP_BITS(TAP_BITS)) bus ();

    clk_div_bank #(
        .N_CH      (N_CH),
        .DIV_W     (DIV_W),
        .TAP_BITS  (TAP_BITS),
        .RESET_DIV (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q [N_CH][$];
    int   since [N_CH];
    exp_t mon_e;
    int   align_tbl [3] = '{2, 6, 5};
    int   waited;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    task automatic push(input int c, input int lvl, input int hp);
        exp_t e;
        e.lvl = lvl;
        e.hp  = hp;
        exp_q[c].push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drained(input string tag);
        for (int c = 0; c < N_CH; c++)
            check($sformatf("%s_drain_ch%0d", tag, c), exp_q[c].size(), 0);
    endtask

    // Monitor: on every tick, the counted enabled cycles since the previous
    // tick (or sync/reset) is the half-period; compare against the queue head.
    always begin
        @(posedge clk);
        #2;
        for (int c = 0; c < N_CH; c++) begin
            if (!rst_n || bus.sync) begin
                since[c] = 1;
            end else if (bus.en) begin
                if (bus.tick[c]) begin
                    if (exp_q[c].size() > 0) begin
                        mon_e = exp_q[c].pop_front();
                        check($sformatf("ch%0d_halfper", c), since[c], mon_e.hp);
                        check($sformatf("ch%0d_level", c), int'(bus.clk_out[c]), mon_e.lvl);
                    end
                    since[c] = 1;
                end else begin
                    since[c] = since[c] + 1;
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.sync      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_div   = '0;
        cyc(2);
        check("rst_clk_out", int'(bus.clk_out), 0);
        check("rst_tick", int'(bus.tick), 0);
        check("rst_tap", int'(bus.tap), 0);
        check("rst_ready", int'(bus.cfg_ready), 1);

        // Divisor 0 out of reset: every channel toggles every cycle.
        for (int i = 1; i <= 16; i++)
            for (int c = 0; c < N_CH; c++) push(c, i % 2, period(0) / 2);
        rst_n  = 1'b1;
        bus.en = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            cyc(1);
            check($sformatf("tap_%0d", i), int'(bus.tap), i % 16);
            check($sformatf("div0_clk_%0d", i), int'(bus.clk_out), (i % 2) ? 7 : 0);
            check($sformatf("div0_tick_%0d", i), int'(bus.tick), 7);
        end

        // ch1 <= 2 while its clk_out is high, then a queued second write of 1.
        push(1, 0, 1); push(1, 1, 1); push(1, 0, 1);
        push(1, 1, period(2) / 2); push(1, 0, period(2) / 2);
        push(1, 1, period(1) / 2); push(1, 0, period(1) / 2);
        push(0, 0, 1); push(0, 1, 1); push(0, 0, 1); push(0, 1, 1);
        bus.cfg_ch  = 2'd1;
        bus.cfg_div = 8'd2;
        #1;
        check("wr1_ready", int'(bus.cfg_ready), 1);
        bus.cfg_valid = 1'b1;
        cyc(1);
        bus.cfg_div = 8'd1;
        #1;
        check("wr2_stall", int'(bus.cfg_ready), 0);
        waited = 0;
        while (!bus.cfg_ready && waited < 20) begin
            cyc(1);
            #1;
            waited++;
        end
        check("wr2_wait_cycles", waited, 2);
        cyc(1);
        bus.cfg_valid = 1'b0;
        #1;
        check("wr2_taken", int'(bus.cfg_ready), 0);
        cyc(9);
        drained("wr");

        // ch0 <= 3 left pending, then sync together with a ch2 <= 2 write.
        cyc(1);
        bus.cfg_ch  = 2'd0;
        bus.cfg_div = 8'd3;
        #1;
        check("wr0_ready", int'(bus.cfg_ready), 1);
        bus.cfg_valid = 1'b1;
        cyc(1);
        bus.cfg_valid = 1'b0;
        #1;
        check("wr0_pending", int'(bus.cfg_ready), 0);
        for (int k = 0; k < 4; k++) begin
            push(0, (k + 1) % 2, period(3) / 2);
            push(1, (k + 1) % 2, period(1) / 2);
            push(2, (k + 1) % 2, period(2) / 2);
        end
        bus.cfg_ch    = 2'd2;
        bus.cfg_div   = 8'd2;
        bus.cfg_valid = 1'b1;
        bus.sync      = 1'b1;
        cyc(1);
        bus.sync      = 1'b0;
        bus.cfg_valid = 1'b0;
        check("sync_clk_out", int'(bus.clk_out), 0);
        check("sync_tick", int'(bus.tick), 0);
        check("sync_tap", int'(bus.tap), 0);
        bus.cfg_ch = 2'd0;
        #1;
        check("sync_ready_ch0", int'(bus.cfg_ready), 1);
        bus.cfg_ch = 2'd2;
        #1;
        check("sync_ready_ch2", int'(bus.cfg_ready), 1);
        cyc(1);
        check("align_0", int'(bus.clk_out), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check($sformatf("align_%0d", i + 1), int'(bus.clk_out), align_tbl[i]);
        end
        cyc(13);
        drained("sync");

        // Freeze mid-period of ch0 (cnt=1 of 3); a write lands but is not applied.
        check("frz_pre_clk", int'(bus.clk_out), 4);
        check("frz_pre_tap", int'(bus.tap), 1);
        push(0, 1, period(3) / 2);
        bus.en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc(1);
            check($sformatf("frz_clk_%0d", i), int'(bus.clk_out), 4);
            check($sformatf("frz_tap_%0d", i), int'(bus.tap), 1);
            check($sformatf("frz_tick_%0d", i), int'(bus.tick), 0);
            if (i == 1) begin
                bus.cfg_ch  = 2'd1;
                bus.cfg_div = 8'd0;
                #1;
                check("frz_cfg_ready", int'(bus.cfg_ready), 1);
                bus.cfg_valid = 1'b1;
            end else begin
                bus.cfg_valid = 1'b0;
                #1;
                check($sformatf("frz_pend_%0d", i), int'(bus.cfg_ready), 0);
            end
        end
        bus.en = 1'b1;
        cyc(1);
        check("thaw_clk_1", int'(bus.clk_out), 2);
        check("thaw_tap_1", int'(bus.tap), 2);
        check("thaw_pend_1", int'(bus.cfg_ready), 0);
        cyc(1);
        check("thaw_clk_2", int'(bus.clk_out), 2);
        check("thaw_pend_2", int'(bus.cfg_ready), 0);
        cyc(1);
        check("thaw_clk_3", int'(bus.clk_out), 1);
        check("thaw_tap_3", int'(bus.tap), 4);
        check("thaw_applied", int'(bus.cfg_ready), 1);

        // Out-of-range channel select: accepted and discarded.
        bus.cfg_ch    = 2'd3;
        bus.cfg_div   = 8'd9;
        bus.cfg_valid = 1'b1;
        #1;
        check("oor_ready", int'(bus.cfg_ready), 1);
        cyc(1);
        bus.cfg_valid = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            bus.cfg_ch = 2'(c);
            #1;
            check($sformatf("oor_idle_ch%0d", c), int'(bus.cfg_ready), 1);
        end
        cyc(1);
        push(0, 1, period(3) / 2); push(0, 0, period(3) / 2);
        push(1, 1, period(0) / 2); push(1, 0, period(0) / 2);
        push(2, 1, period(2) / 2); push(2, 0, period(2) / 2);
        bus.sync = 1'b1;
        cyc(1);
        bus.sync = 1'b0;
        cyc(9);
        drained("oor");
        check("arst_pre_tap", int'(bus.tap), 9);
        check("arst_pre_clk", int'(bus.clk_out), 6);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_clk_out", int'(bus.clk_out), 0);
        check("arst_tick", int'(bus.tick), 0);
        check("arst_tap", int'(bus.tap), 0);
        cyc(1);
        bus.cfg_ch = 2'd0;
        #1;
        check("arst_ready", int'(bus.cfg_ready), 1);
        rst_n = 1'b1;
        cyc(1);
        check("post_rst_clk_1", int'(bus.clk_out), 7);
        check("post_rst_tap_1", int'(bus.tap), 1);
        cyc(1);
        check("post_rst_clk_2", int'(bus.clk_out), 0);
        check("post_rst_tick_2", int'(bus.tick), 7);
        drained("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
